h_dmux4way16_reg: RTL and testbench

Registered 1-to-4 demultiplexer for 16-bit words: accepts one word per cycle on a valid/ready input and delivers it to one of four output channels chosen by a 2-bit select. Each channel has a one-entry output register with its own valid/ready handshake and a per-channel accepted-word counter. It is the distribution counterpart of the 4-way 16-bit mux and sits between a single producer (ALU/bus master) and four independent consumers.

---
 rtl/h_dmux_pkg.sv | 24 ++
 rtl/h_chan_reg16.sv | 48 ++++
 rtl/h_dmux4way16_reg.sv | 74 +++++++
 tb/tb_h_dmux4way16_reg.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/h_dmux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : h_dmux_pkg
//  Description : Shared definitions for the registered 4-way 16-bit demux:
//                channel index constants and default widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package h_dmux_pkg;

    // Channel index encoding used on the select input
    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

    // Number of output channels
    localparam int NUM_CH = 4;

    // Default data word width and per-channel counter width
    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 8;

endpackage : h_dmux_pkg
`default_nettype wire

// File: rtl/h_chan_reg16.sv
`default_nettype none
// ============================================================================
//  Module      : h_chan_reg16
//  Description : One output channel of the demux: a single-entry data
//                register with a valid bit (EMPTY/FULL) and a wrapping
//                accepted-word counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module h_chan_reg16 #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic [CNT_W-1:0] cnt
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [CNT_W-1:0] r_cnt;

    // Load takes priority over drain so a simultaneous drain+load keeps the
    // channel full with the new word (full throughput on one channel).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else if (load) begin
            r_data  <= in_data;
            r_valid <= 1'b1;
            r_cnt   <= r_cnt + CNT_W'(1);
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign data  = r_data;
    assign valid = r_valid;
    assign cnt   = r_cnt;

endmodule : h_chan_reg16
`default_nettype wire

// File: rtl/h_dmux4way16_reg.sv
`default_nettype none
// ============================================================================
//  Module      : h_dmux4way16_reg
//  Description : Registered 1-to-4 demultiplexer for 16-bit words. One
//                valid/ready input is routed by a 2-bit select into one of
//                four single-entry output registers, each with its own
//                valid/ready handshake and accepted-word counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module h_dmux4way16_reg
    import h_dmux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [1:0]              in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH*CNT_W-1:0] cnt
);

    logic [NUM_CH-1:0] w_valid;
    logic [NUM_CH-1:0] w_load;
    logic              w_sel_free;
    logic              w_acc;

    // Readiness depends only on the selected channel, so a stalled channel
    // never blocks traffic aimed at the others. Held low during reset.
    assign w_sel_free = !w_valid[in_sel] || out_ready[in_sel];
    assign in_ready   = rst_n && w_sel_free;
    assign w_acc      = in_valid && in_ready;

    // Decode the select into a one-hot load strobe for the accepted word
    always_comb begin
        w_load = '0;
        if (w_acc) begin
            case (in_sel)
                CH_A:    w_load[0] = 1'b1;
                CH_B:    w_load[1] = 1'b1;
                CH_C:    w_load[2] = 1'b1;
                CH_D:    w_load[3] = 1'b1;
                default: w_load    = '0;
            endcase
        end
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
            h_chan_reg16 #(
                .WIDTH (WIDTH),
                .CNT_W (CNT_W)
            ) u_chan (
                .clk       (clk),
                .rst_n     (rst_n),
                .load      (w_load[g]),
                .in_data   (in_data),
                .out_ready (out_ready[g]),
                .data      (out_data[g*WIDTH +: WIDTH]),
                .valid     (w_valid[g]),
                .cnt       (cnt[g*CNT_W +: CNT_W])
            );
        end
    endgenerate

    assign out_valid = w_valid;

endmodule : h_dmux4way16_reg
`default_nettype wire

// File: tb/tb_h_dmux4way16_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_h_dmux4way16_reg
//  Description : Self-checking bench for h_dmux4way16_reg with a
//                per-channel scoreboard and directed + random stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_h_dmux4way16_reg;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] cnt;

    int errors = 0;
    int checks = 0;

    // Scoreboard: words expected on each channel, oldest first
    logic [15:0] sb [4][$];
    logic [7:0]  m_cnt [4];
    logic        last_stall;

    h_dmux4way16_reg #(.WIDTH(16), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cnt       (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            sb[k].delete();
            m_cnt[k] = 8'd0;
        end
    endtask

    // One clock cycle: check DUT against the scoreboard mid-cycle, then
    // apply the accept/drain effects at the rising edge.
    // Called #1 after a rising edge with inputs already driven.
    task automatic cycle();
        logic       exp_ready;
        logic [3:0] drain;
        logic       acc;
        @(negedge clk);
        exp_ready = (sb[in_sel].size() == 0) || out_ready[in_sel];
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        for (int k = 0; k < 4; k++) begin
            chk("out_valid", 64'(out_valid[k]), 64'(sb[k].size() != 0));
            if (sb[k].size() != 0)
                chk("out_data", 64'(out_data[k*16 +: 16]), 64'(sb[k][0]));
            chk("cnt", 64'(cnt[k*8 +: 8]), 64'(m_cnt[k]));
            drain[k] = (sb[k].size() != 0) && out_ready[k];
        end
        acc = in_valid && exp_ready;
        last_stall = in_valid && !exp_ready;
        @(posedge clk);
        for (int k = 0; k < 4; k++)
            if (drain[k]) void'(sb[k].pop_front());
        if (acc) begin
            sb[in_sel].push_back(in_data);
            m_cnt[in_sel] = m_cnt[in_sel] + 8'd1;
        end
        #1;
    endtask

    initial begin
        // ---------------- reset held with in_valid high ----------------
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        in_data   = 16'hFFFF;
        out_ready = 4'h0;
        last_stall = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_cnt", 64'(cnt), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // ---------------- routing, one word per channel ----------------
        out_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] w;
            w = 16'hA001 + 16'h1001 * 16'(i);
            in_valid = 1'b1;
            in_sel   = 2'(i);
            in_data  = w;
            cycle();
            chk("route_onehot", 64'(out_valid), 64'(4'b0001 << i));
            chk("route_data", 64'(out_data[i*16 +: 16]), 64'(w));
        end
        in_valid = 1'b0;
        cycle();
        chk("route_cnt", 64'(cnt), 64'h01010101);

        // ---------------- backpressure on channel c ----------------
        out_ready = 4'b1011;
        in_valid  = 1'b1;
        in_sel    = 2'd2;
        in_data   = 16'h1234;
        cycle();
        in_data = 16'h5678;
        chk("bp_stall_ready", 64'(in_ready), 64'd0);
        cycle();
        chk("bp_hold_data", 64'(out_data[47:32]), 64'h1234);
        chk("bp_hold_valid", 64'(out_valid[2]), 64'd1);
        in_sel = 2'd0;
        #1;
        chk("bp_other_ready", 64'(in_ready), 64'd1);
        in_sel = 2'd2;
        out_ready[2] = 1'b1;
        #1;
        cycle();
        chk("bp_release_data", 64'(out_data[47:32]), 64'h5678);
        chk("bp_release_valid", 64'(out_valid[2]), 64'd1);
        in_valid = 1'b0;
        cycle();

        // ---------------- same-channel fill + drain ----------------
        out_ready = 4'hF;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_sel   = 2'd3;
            in_data  = 16'h3000 + 16'(i);
            #1;
            chk("ff_ready", 64'(in_ready), 64'd1);
            cycle();
            chk("ff_valid", 64'(out_valid[3]), 64'd1);
        end
        in_valid = 1'b0;
        chk("ff_cnt", 64'(cnt[31:24]), 64'd11);
        cycle();

        // ---------------- asynchronous reset mid-cycle with b full ----------------
        out_ready = 4'b1101;
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        in_data   = 16'hBEEF;
        cycle();
        in_valid = 1'b0;
        chk("ar_b_full", 64'(out_valid[1]), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid_drop", 64'(out_valid), 64'd0);
        chk("ar_cnt_clear", 64'(cnt), 64'd0);
        chk("ar_data_clear", out_data, 64'd0);
        chk("ar_in_ready", 64'(in_ready), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ---------------- counter wrap on channel a ----------------
        out_ready = 4'hF;
        for (int i = 1; i <= 256; i++) begin
            in_valid = 1'b1;
            in_sel   = 2'd0;
            in_data  = 16'(i);
            cycle();
            if (i == 255) chk("wrap_ff", 64'(cnt[7:0]), 64'hFF);
        end
        chk("wrap_00", 64'(cnt[7:0]), 64'h00);
        chk("wrap_others", 64'(cnt[31:8]), 64'd0);
        in_valid = 1'b0;
        cycle();

        // ---------------- random soak ----------------
        last_stall = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (!last_stall) begin
                in_valid = 1'($urandom_range(0, 1));
                in_sel   = 2'($urandom_range(0, 3));
                in_data  = 16'($urandom);
            end
            out_ready = 4'($urandom);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 4'hF;
        cycle();
        cycle();
        chk("soak_empty", 64'(out_valid), 64'd0);
        for (int k = 0; k < 4; k++)
            chk("soak_sb_empty", 64'(sb[k].size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_h_dmux4way16_reg
`default_nettype wire
